// File: rtl/bcd_seg_scan_pkg.sv
// rtl/bcd_seg_scan_pkg.sv - shared scan states and seven-segment glyph constants
package bcd_seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SCAN_ONES = 2'd1,
      SCAN_TENS = 2'd2
   } state_t;

   // Segment order is gfedcba, active high
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// rtl/bcd_seg_scan_if.sv - packed-BCD word handshake into the scanner
interface bcd_seg_scan_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_;
   logic       blank_lz;

   modport master (
      output in_valid,
      output in_,
      output blank_lz,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_,
      input  blank_lz,
      output in_ready
   );

endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - one BCD digit to seven-segment glyph, dash for 10..15
module bcd_to_seg7
   import bcd_seg_scan_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - two-digit multiplexed seven-segment scanner
// Words are only taken at frame boundaries so a displayed frame never mixes two words.
module bcd_seg_scan
   import bcd_seg_scan_pkg::*;
#(
   parameter int PRESCALE = 4
)(
   input  logic           clk,
   input  logic           reset_n,
   bcd_seg_scan_if.slave  in_bus,
   output logic [6:0]     seg,
   output logic [1:0]     digit_en,
   output logic           err
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [7:0]    held;
   logic          blank_held;
   logic          ready;
   logic          accept;
   logic [3:0]    digit_sel;
   logic [6:0]    seg_dec;

   assign ready           = (state == IDLE) || ((state == SCAN_TENS) && (cnt == CNT_LAST));
   assign in_bus.in_ready = ready;
   assign accept          = in_bus.in_valid && ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SCAN_ONES;
               cnt_nxt   = '0;
            end
         end
         SCAN_ONES: begin
            if (cnt == CNT_LAST) begin
               state_nxt = SCAN_TENS;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         SCAN_TENS: begin
            if (cnt == CNT_LAST) begin
               state_nxt = SCAN_ONES;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Word, blanking choice and error flag are captured as one unit on accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held       <= '0;
         blank_held <= 1'b0;
         err        <= 1'b0;
      end else if (accept) begin
         held       <= in_bus.in_;
         blank_held <= in_bus.blank_lz;
         err        <= (in_bus.in_[7:4] > 4'd9) || (in_bus.in_[3:0] > 4'd9);
      end
   end

   assign digit_sel = (state == SCAN_TENS) ? held[7:4] : held[3:0];

   bcd_to_seg7 u_dec (
      .digit (digit_sel),
      .seg   (seg_dec)
   );

   always_comb begin
      seg      = '0;
      digit_en = 2'b00;
      case (state)
         SCAN_ONES: begin
            digit_en = 2'b01;
            seg      = seg_dec;
         end
         SCAN_TENS: begin
            // A blanked leading zero keeps its time slot so brightness stays uniform
            digit_en = 2'b10;
            seg      = (blank_held && (held[7:4] == 4'd0)) ? 7'h00 : seg_dec;
         end
         default: begin
            digit_en = 2'b00;
            seg      = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - randomized and directed checks against a frame-timing model
module tb_bcd_seg_scan;

   localparam int P = 4;

   logic       clk;
   logic       reset_n;
   logic [6:0] seg;
   logic [1:0] digit_en;
   logic       err;

   bcd_seg_scan_if bus ();

   bcd_seg_scan #(.PRESCALE(P)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_bus   (bus.slave),
      .seg      (seg),
      .digit_en (digit_en),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [6:0] glyph [16];

   // Model: display timing is derived from the cycle count since the last accept
   bit         m_idle;
   int         cyc;
   int         t0;
   logic [7:0] m_word;
   logic       m_blank;
   logic       m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int phase();
      return (cyc - t0) % (2 * P);
   endfunction

   function automatic logic m_ready();
      if (m_idle) return 1'b1;
      return phase() == 2 * P - 1;
   endfunction

   task automatic model_reset();
      m_idle  = 1'b1;
      m_word  = 8'h00;
      m_blank = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic check_outputs();
      logic [6:0] es;
      logic [1:0] ee;
      if (m_idle) begin
         es = 7'h00;
         ee = 2'b00;
      end else if (phase() < P) begin
         es = glyph[m_word[3:0]];
         ee = 2'b01;
      end else begin
         es = (m_blank && m_word[7:4] == 4'd0) ? 7'h00 : glyph[m_word[7:4]];
         ee = 2'b10;
      end
      check("seg", 32'(seg), 32'(es));
      check("digit_en", 32'(digit_en), 32'(ee));
      check("in_ready", 32'(bus.in_ready), 32'(m_ready()));
      check("err", 32'(err), 32'(m_err));
   endtask

   task automatic step(input logic v, input logic [7:0] w, input logic b);
      logic acc;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_      = w;
      bus.blank_lz = b;
      acc = v && m_ready();
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
         m_idle  = 1'b0;
         t0      = cyc;
         m_word  = w;
         m_blank = b;
         m_err   = (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
      end
      check_outputs();
   endtask

   task automatic offer(input logic [7:0] w, input logic b, input int hold);
      int n;
      n = 0;
      while (!m_ready() && n < 4 * P) begin
         step(1'b0, 8'h00, $urandom_range(0, 1));
         n++;
      end
      if (!m_ready()) check("ready_timeout", 32'd0, 32'd1);
      step(1'b1, w, b);
      for (int i = 0; i < hold; i++) step(1'b0, 8'h00, $urandom_range(0, 1));
   endtask

   initial begin
      glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
      glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
      glyph[8]  = 7'h7F; glyph[9]  = 7'h6F;
      for (int i = 10; i < 16; i++) glyph[i] = 7'h40;

      cyc = 0;
      t0  = 0;
      model_reset();
      bus.in_valid = 1'b0;
      bus.in_      = 8'h00;
      bus.blank_lz = 1'b0;
      reset_n      = 1'b0;
      #1;
      check_outputs();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

      // Basic scan, then a word held pending across a frame boundary
      offer(8'h42, 1'b0, 12);
      for (int i = 0; i < 20; i++) step(1'b1, 8'h99, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

      offer(8'h07, 1'b1, 2 * P + 3);
      offer(8'h07, 1'b0, 2 * P + 3);
      offer(8'h3C, 1'b0, 2 * P + 2);
      offer(8'h15, 1'b0, 2 * P + 2);

      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));

      // Asynchronous reset in the middle of a tens slot
      offer(8'h58, 1'b0, 0);
      for (int i = 0; i < 4 * P && (m_idle || phase() < P + 1); i++)
         step(1'b0, 8'h00, 1'b0);
      check("mid_tens", 32'(digit_en), 32'd2);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      reset_n = 1'b1;
      offer(8'h10, 1'b0, 2 * P + 1);

      for (int i = 0; i < 200; i++)
         step(($urandom_range(0, 1) == 0), {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))},
              1'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 Parameter: PRESCALE, default 4, is the number of clock cycles each digit is driven; legal values SHALL be >= 1.
REQ-002 Port: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  upstream offers a packed-BCD word.
REQ-005 Port: in_ready  output  1  block accepts the word this cycle.
REQ-006 Port: in_  input  8  packed BCD word; [7:4] is tens, [3:0] is ones.
REQ-007 Port: blank_lz  input  1  blank a zero tens digit; sampled only on accept.
REQ-008 Port: seg  output  7  active-high segments; bit0=a through bit6=g.
REQ-009 Port: digit_en  output  2  one-hot digit select; bit0=ones, bit1=tens, 00=display off.
REQ-010 Port: err  output  1  held word contains a nibble > 9.

Function
REQ-011 An accept SHALL occur in any cycle where in_valid and in_ready are both 1; the word, blank_lz and the error flag SHALL be captured together.
REQ-012 The FSM SHALL have the states IDLE, SCAN_ONES and SCAN_TENS, plus a prescale counter cnt in 0..PRESCALE-1.
REQ-013 IDLE SHALL transition to SCAN_ONES with cnt=0 on accept; otherwise it SHALL stay in IDLE.
REQ-014 In SCAN_ONES, when cnt==PRESCALE-1, the FSM SHALL transition to SCAN_TENS with cnt=0; otherwise cnt SHALL increment.
REQ-015 In SCAN_TENS, when cnt==PRESCALE-1, the FSM SHALL transition to SCAN_ONES with cnt=0; otherwise cnt SHALL increment.
REQ-016 in_ready SHALL be 1 in IDLE, and 1 in SCAN_TENS when cnt==PRESCALE-1; it SHALL be 0 in all other cycles, giving tear-free frame-boundary updates.
REQ-017 A newly accepted word SHALL be displayed starting in the cycle after the accept, beginning with the ones digit; a displayed frame SHALL never mix two words.
REQ-018 digit_en SHALL be 00 in IDLE, 01 in SCAN_ONES and 10 in SCAN_TENS.
REQ-019 seg SHALL be 0 in IDLE; in the scan states it SHALL be the decode of the selected held digit.
REQ-020 The digit decode (gfedcba, hex) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; any value 10-15 SHALL decode to 40 (dash).
REQ-021 If the captured blank_lz=1 and the held tens digit is 0, seg SHALL be 00 during SCAN_TENS; digit_en SHALL still scan so that duty is unchanged.
REQ-022 err SHALL equal the OR of (tens>9) and (ones>9) for the last accepted word, and SHALL change only on accept.
REQ-023 seg, digit_en, in_ready and err SHALL be functions of registered state only, with no combinational path from any input.
REQ-024 With PRESCALE=1, the scan states SHALL alternate every cycle, and in_ready SHALL be 1 in every SCAN_TENS cycle.

Reset
REQ-025 While reset_n=0, the block SHALL asynchronously force state=IDLE, cnt=0, held word=00, captured blank_lz=0 and err=0.
REQ-026 Consequently, during and after reset, seg=00, digit_en=00 and in_ready=1.
REQ-027 Reset asserted mid-scan SHALL take effect immediately with no completion of the frame; the first accept after release SHALL behave as REQ-013.

Structure
REQ-028 A shared package SHALL hold the state enum, the ten segment constants and the dash constant.
REQ-029 Digit decoding SHALL live in one combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit out), instantiated once and fed by a digit mux.
REQ-030 The counter width SHALL be $clog2(PRESCALE), with a minimum of 1 bit.

Verification (PRESCALE=4 unless stated)
REQ-031 Reset and idle: release reset, hold in_valid=0 -> seg=00, digit_en=00, in_ready=1 and err=0 indefinitely.
REQ-032 Basic scan: accept 0x42 at cycle t ->
- t+1..t+4: digit_en=01, seg=5B.
- t+5..t+8: digit_en=10, seg=66.
- in_ready=1 only at t+8, repeating every 8 cycles.
REQ-033 Frame-boundary update:
- While 0x42 is displayed, hold in_valid=1 with in_=0x99 -> no accept until the last SCAN_TENS cycle.
- The next cycle shows digit_en=01, seg=6F.
- No frame ever pairs 2 with 9.
REQ-034 Leading-zero blanking:
- Accept 0x07 with blank_lz=1 -> tens slot has seg=00, digit_en=10.
- Repeat with blank_lz=0 -> tens slot has seg=3F.
- Toggling blank_lz without an accept has no effect.
REQ-035 Invalid digit:
- Accept 0x3C -> err=1 from t+1; ones slot seg=40, tens slot seg=4F.
- A later accept of 0x15 -> err=0 from the cycle after that accept.
REQ-036 Reset mid-operation: assert reset_n=0 mid SCAN_TENS -> same cycle seg=00, digit_en=00, in_ready=1, err=0; after release, accepting 0x10 -> ones digit shows first (seg=3F).
